// File: rtl/block_mem_arbiter_pkg.sv
// Shared codes for the block-memory command port and the arbiter state encoding.
package block_mem_arbiter_pkg;

  localparam logic [1:0] BM_FUNC_CLEAR = 2'b00;
  localparam logic [1:0] BM_FUNC_LOAD  = 2'b01;
  localparam logic [1:0] BM_FUNC_LEFT  = 2'b10;
  localparam logic [1:0] BM_FUNC_RIGHT = 2'b11;

  localparam logic [1:0] BM_STAGE_0 = 2'b00;
  localparam logic [1:0] BM_STAGE_1 = 2'b01;
  localparam logic [1:0] BM_STAGE_2 = 2'b10;
  localparam logic [1:0] BM_STAGE_3 = 2'b11;

  typedef enum logic [1:0] {
    ST_ARB_IDLE  = 2'd0,
    ST_ARB_ISSUE = 2'd1,
    ST_ARB_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/block_mem_arbiter_if.sv
// Block-memory command port: the arbiter drives the command (master), the memory answers (slave).
interface block_mem_arbiter_if #(
  parameter int ROW_W = 5,
  parameter int COL_W = 5
);
  logic             bm_enable;
  logic [1:0]       bm_func;
  logic [1:0]       bm_stage;
  logic [ROW_W-1:0] bm_row;
  logic [COL_W-1:0] bm_col;
  logic             bm_ready;
  logic [3:0]       bm_block;

  modport master (
    output bm_enable, bm_func, bm_stage, bm_row, bm_col,
    input  bm_ready, bm_block
  );

  modport slave (
    input  bm_enable, bm_func, bm_stage, bm_row, bm_col,
    output bm_ready, bm_block
  );
endinterface

// File: rtl/block_mem_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning upward from (ptr+1) mod REQ_NUM.
module block_mem_arbiter_rr_pick #(
  parameter int REQ_NUM = 4,
  parameter int IDX_W   = 2
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest candidate is written last and wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = REQ_NUM; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % REQ_NUM);
      if (req[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_mem_arbiter.sv
// Round-robin arbiter for the shared block-memory command port, one transaction in flight.
// Optional BM_ARB_PRIORITY0_EN: requester 0 pre-empts round-robin whenever it requests.
module block_mem_arbiter
  import block_mem_arbiter_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int ROW_W   = 5,
  parameter int COL_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REQ_NUM-1:0]       req,
  input  logic [REQ_NUM*2-1:0]     req_func,
  input  logic [REQ_NUM*2-1:0]     req_stage,
  input  logic [REQ_NUM*ROW_W-1:0] req_row,
  input  logic [REQ_NUM*COL_W-1:0] req_col,
  output logic [REQ_NUM-1:0]       done,
  output logic                     err,
  output logic [3:0]               rd_block,
  output logic                     busy,
  block_mem_arbiter_if.master      bm
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]       func_arr  [REQ_NUM];
  logic [1:0]       stage_arr [REQ_NUM];
  logic [ROW_W-1:0] row_arr   [REQ_NUM];
  logic [COL_W-1:0] col_arr   [REQ_NUM];

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_slice
    assign func_arr[gi]  = req_func[gi*2 +: 2];
    assign stage_arr[gi] = req_stage[gi*2 +: 2];
    assign row_arr[gi]   = req_row[gi*ROW_W +: ROW_W];
    assign col_arr[gi]   = req_col[gi*COL_W +: COL_W];
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       func_q, func_d;
  logic [1:0]       stage_q, stage_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [REQ_NUM-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       rd_block_q, rd_block_d;

  logic [IDX_W-1:0] rr_idx, pick_idx;
  logic             rr_vld;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  block_mem_arbiter_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req       (req),
    .ptr       (ptr_q),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

`ifdef BM_ARB_PRIORITY0_EN
  assign pick_idx = req[0] ? '0 : rr_idx;
`else
  assign pick_idx = rr_idx;
`endif

  // The last WAIT cycle is the one whose increment reaches TIMEOUT.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB_IDLE:  if (rr_vld) state_d = ST_ARB_ISSUE;
      ST_ARB_ISSUE: state_d = ST_ARB_WAIT;
      ST_ARB_WAIT:  if (bm.bm_ready || timeout_hit) state_d = ST_ARB_IDLE;
      default:      state_d = ST_ARB_IDLE;
    endcase
  end

  always_comb begin
    bm.bm_enable = (state_q == ST_ARB_ISSUE);
    busy         = (state_q == ST_ARB_ISSUE) || (state_q == ST_ARB_WAIT);
    bm.bm_func   = func_q;
    bm.bm_stage  = stage_q;
    bm.bm_row    = row_q;
    bm.bm_col    = col_q;
    done         = done_q;
    err          = err_q;
    rd_block     = rd_block_q;
  end

  always_comb begin
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    func_d     = func_q;
    stage_d    = stage_q;
    row_d      = row_q;
    col_d      = col_q;
    done_d     = '0;
    err_d      = 1'b0;
    rd_block_d = 4'h0;
    unique case (state_q)
      ST_ARB_IDLE: begin
        if (rr_vld) begin
          idx_d   = pick_idx;
          func_d  = func_arr[pick_idx];
          stage_d = stage_arr[pick_idx];
          row_d   = row_arr[pick_idx];
          col_d   = col_arr[pick_idx];
        end
      end
      ST_ARB_ISSUE: cnt_d = '0;
      ST_ARB_WAIT: begin
        if (bm.bm_ready || timeout_hit) begin
          done_d[idx_q] = 1'b1;
          err_d         = !bm.bm_ready;
          rd_block_d    = bm.bm_ready ? bm.bm_block : 4'h0;
`ifdef BM_ARB_PRIORITY0_EN
          if (idx_q != '0) ptr_d = idx_q;
`else
          ptr_d = idx_q;
`endif
        end
        cnt_d = cnt_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q      <= '0;
      ptr_q      <= IDX_W'(REQ_NUM - 1);
      cnt_q      <= '0;
      func_q     <= '0;
      stage_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rd_block_q <= 4'h0;
    end else begin
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      func_q     <= func_d;
      stage_q    <= stage_d;
      row_q      <= row_d;
      col_q      <= col_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_block_q <= rd_block_d;
    end
  end

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Directed bench for block_mem_arbiter: table of single transactions plus back-to-back,
// priority and reset-abort sequences. Expectations follow BM_ARB_PRIORITY0_EN when defined.
module tb_block_mem_arbiter;
  import block_mem_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int TO = 15;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  req_func;
  logic [2*N-1:0]  req_stage;
  logic [N*RW-1:0] req_row;
  logic [N*CW-1:0] req_col;
  logic [N-1:0]    done;
  logic            err;
  logic [3:0]      rd_block;
  logic            busy;

  block_mem_arbiter_if #(.ROW_W(RW), .COL_W(CW)) bm ();

  block_mem_arbiter #(
    .REQ_NUM (N),
    .ROW_W   (RW),
    .COL_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_func  (req_func),
    .req_stage (req_stage),
    .req_row   (req_row),
    .req_col   (req_col),
    .done      (done),
    .err       (err),
    .rd_block  (rd_block),
    .busy      (busy),
    .bm        (bm)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  localparam logic [1:0]    FUNC_TAB  [N] = '{BM_FUNC_CLEAR, BM_FUNC_LOAD, BM_FUNC_LEFT, BM_FUNC_RIGHT};
  localparam logic [1:0]    STAGE_TAB [N] = '{BM_STAGE_1, BM_STAGE_2, BM_STAGE_3, BM_STAGE_0};
  localparam logic [RW-1:0] ROW_TAB   [N] = '{5'd3, 5'd7, 5'd12, 5'd30};
  localparam logic [CW-1:0] COL_TAB   [N] = '{5'd5, 5'd9, 5'd17, 5'd1};

  typedef struct {
    logic [3:0] req;
    int         dly;      // ready this many cycles after bm_enable; 0 = never (timeout)
    logic [3:0] blk;
    logic [1:0] exp_idx;
    bit         exp_err;
    logic [3:0] exp_rd;
    bit         hold;     // keep req asserted after done (back-to-back)
    bit         drop;     // release req during ISSUE
    bit         stray;    // bm_ready pulsed in IDLE and ISSUE
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int txn_no   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    bm.bm_ready = 1'b0;
    bm.bm_block = 4'h0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, output int done_cyc);
    int n;
    int lat;
    int exp_lat;
    bit got;
    logic [3:0] exp_done;
    done_cyc = -1;
    req = v.req;
    bm.bm_ready = v.stray;
    bm.bm_block = v.stray ? 4'hF : 4'h0;
    n = 0;
    do begin
      step();
      n++;
    end while (!bm.bm_enable && n < 8);
    chk("grant_latency", 32'(n), 32'd1);
    chk("issue_busy", 32'(busy), 32'd1);
    chk("bm_func", 32'(bm.bm_func), 32'(FUNC_TAB[v.exp_idx]));
    chk("bm_stage", 32'(bm.bm_stage), 32'(STAGE_TAB[v.exp_idx]));
    chk("bm_row", 32'(bm.bm_row), 32'(ROW_TAB[v.exp_idx]));
    chk("bm_col", 32'(bm.bm_col), 32'(COL_TAB[v.exp_idx]));
    if (v.drop) req = '0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= TO + 4 && !got; i++) begin
      step();
      if (i == 1) chk("enable_pulse", 32'(bm.bm_enable), 32'd0);
      if (done != '0) begin
        got = 1'b1;
        lat = i;
      end else begin
        bm.bm_ready = (i == v.dly);
        bm.bm_block = v.blk;
      end
    end
    bm.bm_ready = 1'b0;
    bm.bm_block = 4'h0;
    exp_lat  = (v.dly > 0) ? v.dly + 1 : TO + 1;
    exp_done = 4'b0001 << v.exp_idx;
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("done_onehot", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(v.exp_err));
    chk("rd_block", 32'(rd_block), 32'(v.exp_rd));
    chk("idle_at_done", 32'(busy), 32'd0);
    done_cyc = cyc;
    $display("txn %0d: req=%b done=%b err=%0d rd_block=%0h latency=%0d", txn_no, v.req, done, err, rd_block, lat);
    txn_no++;
    if (!v.hold) begin
      req = '0;
      step();
      chk("done_pulse_width", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    vec_t v;
    int   dc;
    int   prev;
    logic [1:0] seq_a [5];
    logic [1:0] seq_b [6];
    logic [3:0] seen;

    for (int i = 0; i < N; i++) begin
      req_func[i*2 +: 2]   = FUNC_TAB[i];
      req_stage[i*2 +: 2]  = STAGE_TAB[i];
      req_row[i*RW +: RW]  = ROW_TAB[i];
      req_col[i*CW +: CW]  = COL_TAB[i];
    end

    //            req      dly blk    idx    err  rd    hold drop stray
    tbl[0] = '{4'b0001, 2,  4'h4, 2'd0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b1110, 1,  4'hA, 2'd1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'b1010, 0,  4'hE, 2'd3, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'b0011, TO, 4'h7, 2'd0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'b0100, 1,  4'hC, 2'd2, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{4'b1010, 3,  4'h1, 2'd3, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{4'b0110, 1,  4'h5, 2'd1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{4'b0001, 0,  4'h9, 2'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0};

`ifdef BM_ARB_PRIORITY0_EN
    seq_a = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    seq_b = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    seq_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    seq_b = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
`endif

    bm.bm_ready = 1'b0;
    bm.bm_block = 4'h0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rd_block", 32'(rd_block), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bm_enable", 32'(bm.bm_enable), 32'd0);
    chk("reset_bm_cmd", {17'd0, bm.bm_func, bm.bm_stage, bm.bm_row, bm.bm_col}, 32'd0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], dc);

    // Back-to-back with all requesters held: one completion every 3 cycles.
    do_reset();
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      v = '{4'b1111, 1, 4'(k + 1), seq_a[k], 1'b0, 4'(k + 1), 1'b1, 1'b0, 1'b0};
      run_txn(v, dc);
      if (k > 0) chk("b2b_spacing", 32'(dc - prev), 32'd3);
      prev = dc;
    end
    req = '0;
    step();

    // Requesters 0, 1 and 3 held continuously.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      v = '{4'b1011, 2, 4'(k + 8), seq_b[k], 1'b0, 4'(k + 8), 1'b1, 1'b0, 1'b0};
      run_txn(v, dc);
    end
    req = '0;
    step();

    // Reset in WAIT aborts without a completion; fresh request afterwards still served.
    do_reset();
    req = 4'b0001;
    step();
    chk("abort_enable", 32'(bm.bm_enable), 32'd1);
    step();
    step();
    chk("abort_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    req = '0;
    step();
    reset = 1'b0;
    chk("abort_bm_enable", 32'(bm.bm_enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bm_row", 32'(bm.bm_row), 32'd0);
    seen = done;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | done;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    v = '{4'b0100, 1, 4'h6, 2'd2, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0};
    run_txn(v, dc);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
